// File: rtl/vga_text_timing.sv
// Raster timing generator with 8x16 text-cell decode; all outputs registered and mutually aligned.
// Optional blink phase generator enabled by defining VGA_TEXT_TIMING_BLINK_EN.
module vga_text_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       DE,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic [6:0] COL,
  output logic [4:0] ROW,
  output logic [2:0] GLYPH_X,
  output logic [3:0] GLYPH_Y,
  output logic       LINE_START,
  output logic       FRAME_START,
  output logic       BLINK
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FRONT_BEG  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BACK_BEG   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FRONT_BEG  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BACK_BEG   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCS, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCS, V_BACK} v_state_t;

  h_state_t   h_state_r, h_state_s;
  v_state_t   v_state_r, v_state_s;
  logic [9:0] x_s, y_s;
  logic       line_wrap_s, frame_start_s, de_s, hs_s, vs_s, v_act_s;

  // Next-state counters and region FSMs; outputs decode from these so X/Y and flags stay aligned.
  always_comb begin
    line_wrap_s = (X == H_LAST);
    x_s = line_wrap_s ? 10'd0 : (X + 10'd1);
    if (line_wrap_s) begin
      y_s = (Y == V_LAST) ? 10'd0 : (Y + 10'd1);
    end else begin
      y_s = Y;
    end

    h_state_s = h_state_r;
    case (h_state_r)
      H_ACT:   h_state_s = (x_s == H_FRONT_BEG) ? H_FRONT : H_ACT;
      H_FRONT: h_state_s = (x_s == H_SYNC_BEG)  ? H_SYNCS : H_FRONT;
      H_SYNCS: h_state_s = (x_s == H_BACK_BEG)  ? H_BACK  : H_SYNCS;
      H_BACK:  h_state_s = (x_s == 10'd0)       ? H_ACT   : H_BACK;
      default: h_state_s = H_BACK;
    endcase

    v_state_s = v_state_r;
    if (line_wrap_s) begin
      case (v_state_r)
        V_ACT:   v_state_s = (y_s == V_FRONT_BEG) ? V_FRONT : V_ACT;
        V_FRONT: v_state_s = (y_s == V_SYNC_BEG)  ? V_SYNCS : V_FRONT;
        V_SYNCS: v_state_s = (y_s == V_BACK_BEG)  ? V_BACK  : V_SYNCS;
        V_BACK:  v_state_s = (y_s == 10'd0)       ? V_ACT   : V_BACK;
        default: v_state_s = V_BACK;
      endcase
    end else begin
      v_state_s = v_state_r;
    end

    v_act_s       = (v_state_s == V_ACT);
    de_s          = (h_state_s == H_ACT) && v_act_s;
    hs_s          = (h_state_s == H_SYNCS) ? HS_POL : ~HS_POL;
    vs_s          = (v_state_s == V_SYNCS) ? VS_POL : ~VS_POL;
    frame_start_s = (x_s == 10'd0) && (y_s == 10'd0);
  end

  // Registered raster state and every timing/cell output.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      X           <= H_LAST;
      Y           <= V_LAST;
      h_state_r   <= H_BACK;
      v_state_r   <= V_BACK;
      DE          <= 1'b0;
      HSYNC       <= ~HS_POL;
      VSYNC       <= ~VS_POL;
      COL         <= 7'd0;
      ROW         <= 5'd0;
      GLYPH_X     <= 3'd0;
      GLYPH_Y     <= 4'd0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      X           <= x_s;
      Y           <= y_s;
      h_state_r   <= h_state_s;
      v_state_r   <= v_state_s;
      DE          <= de_s;
      HSYNC       <= hs_s;
      VSYNC       <= vs_s;
      COL         <= de_s ? x_s[9:3] : 7'd0;
      GLYPH_X     <= de_s ? x_s[2:0] : 3'd0;
      ROW         <= v_act_s ? y_s[8:4] : 5'd0;
      GLYPH_Y     <= v_act_s ? y_s[3:0] : 4'd0;
      LINE_START  <= (x_s == 10'd0);
      FRAME_START <= frame_start_s;
    end
  end

`ifdef VGA_TEXT_TIMING_BLINK_EN
  logic [4:0] blink_cnt_r;

  // Frame counter: BLINK flips each time 32 frames have elapsed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      blink_cnt_r <= 5'd0;
      BLINK       <= 1'b0;
    end else if (frame_start_s) begin
      blink_cnt_r <= blink_cnt_r + 5'd1;
      BLINK       <= (blink_cnt_r == 5'd31) ? ~BLINK : BLINK;
    end else begin
      blink_cnt_r <= blink_cnt_r;
      BLINK       <= BLINK;
    end
  end
`else
  assign BLINK = 1'b0;
`endif

endmodule

// File: tb/tb_vga_text_timing.sv
// Bench for vga_text_timing: a default 640x480 instance and a tiny-geometry instance for frame-level behaviour.
module tb_vga_text_timing;

  localparam int AHA = 640, AHF = 16, AHS = 96, AHT = 800;
  localparam int AVA = 480, AVF = 10, AVS = 2,  AVT = 525;
  localparam int BHA = 16,  BHF = 2,  BHS = 4,  BHT = 24;
  localparam int BVA = 16,  BVF = 1,  BVS = 2,  BVT = 20;
`ifdef VGA_TEXT_TIMING_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  typedef struct packed {
    logic hs; logic vs; logic de;
    logic [9:0] x; logic [9:0] y;
    logic [6:0] col; logic [4:0] row; logic [2:0] gx; logic [3:0] gy;
    logic ls; logic fs; logic bl;
  } obs_t;

  typedef struct {
    int x; int y;
    logic de; logic [6:0] col; logic [4:0] row; logic [2:0] gx; logic [3:0] gy;
    logic hs; logic ls;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic hs_a, vs_a, de_a, ls_a, fs_a, bl_a;
  logic hs_b, vs_b, de_b, ls_b, fs_b, bl_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [6:0] col_a, col_b;
  logic [4:0] row_a, row_b;
  logic [2:0] gx_a, gx_b;
  logic [3:0] gy_a, gy_b;
  obs_t obs_a, obs_b;

  assign obs_a = {hs_a, vs_a, de_a, x_a, y_a, col_a, row_a, gx_a, gy_a, ls_a, fs_a, bl_a};
  assign obs_b = {hs_b, vs_b, de_b, x_b, y_b, col_b, row_b, gx_b, gy_b, ls_b, fs_b, bl_b};

  vga_text_timing dut_a (
    .CLK(clk), .RESET(rst_a), .HSYNC(hs_a), .VSYNC(vs_a), .DE(de_a), .X(x_a), .Y(y_a),
    .COL(col_a), .ROW(row_a), .GLYPH_X(gx_a), .GLYPH_Y(gy_a),
    .LINE_START(ls_a), .FRAME_START(fs_a), .BLINK(bl_a)
  );

  vga_text_timing #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(2),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .CLK(clk), .RESET(rst_b), .HSYNC(hs_b), .VSYNC(vs_b), .DE(de_b), .X(x_b), .Y(y_b),
    .COL(col_b), .ROW(row_b), .GLYPH_X(gx_b), .GLYPH_Y(gy_b),
    .LINE_START(ls_b), .FRAME_START(fs_b), .BLINK(bl_b)
  );

  int checks = 0;
  int failures = 0;
  int ax, ay, afc, bx, by, bfc;
  obs_t qa[$];
  obs_t qb[$];
  vec_t vecs[13];

  function automatic obs_t model(int x, int y, int ha, int hfp, int hsw, int ht,
                                 int va, int vfp, int vsw, int vt, bit rst, int fc);
    obs_t r;
    r = '0;
    if (rst) begin
      r.hs = 1'b1; r.vs = 1'b1;
      r.x = 10'(ht - 1); r.y = 10'(vt - 1);
    end else begin
      r.x   = 10'(x);
      r.y   = 10'(y);
      r.de  = (x < ha) && (y < va);
      r.hs  = !((x >= ha + hfp) && (x < ha + hfp + hsw));
      r.vs  = !((y >= va + vfp) && (y < va + vfp + vsw));
      r.col = r.de ? 7'(x / 8) : 7'd0;
      r.gx  = r.de ? 3'(x % 8) : 3'd0;
      r.row = (y < va) ? 5'(y / 16) : 5'd0;
      r.gy  = (y < va) ? 4'(y % 16) : 4'd0;
      r.ls  = (x == 0);
      r.fs  = (x == 0) && (y == 0);
      r.bl  = BLINK_ON ? 1'((fc / 32) % 2) : 1'b0;
    end
    return r;
  endfunction

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_obs(string name, obs_t got, obs_t exp, int mx, int my);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at x=%0d y=%0d got=%h expected=%h", name, mx, my, got, exp);
    end
  endtask

  // One clock: advance both reference models, queue their expectations, then compare.
  task automatic tick();
    obs_t ea, eb;
    if (rst_a) begin
      ax = AHT - 1; ay = AVT - 1; afc = 0;
    end else begin
      ax = (ax == AHT - 1) ? 0 : ax + 1;
      if (ax == 0) ay = (ay == AVT - 1) ? 0 : ay + 1;
      if (ax == 0 && ay == 0) afc++;
    end
    if (rst_b) begin
      bx = BHT - 1; by = BVT - 1; bfc = 0;
    end else begin
      bx = (bx == BHT - 1) ? 0 : bx + 1;
      if (bx == 0) by = (by == BVT - 1) ? 0 : by + 1;
      if (bx == 0 && by == 0) bfc++;
    end
    qa.push_back(model(ax, ay, AHA, AHF, AHS, AHT, AVA, AVF, AVS, AVT, rst_a, afc));
    qb.push_back(model(bx, by, BHA, BHF, BHS, BHT, BVA, BVF, BVS, BVT, rst_b, bfc));
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    check_obs("sb_a", obs_a, ea, ax, ay);
    check_obs("sb_b", obs_b, eb, bx, by);
    if (failures >= 40) finish_run();
  endtask

  task automatic run_to_a(int tx, int ty);
    int n = 0;
    while (!(ax == tx && ay == ty) && n < 20000) begin tick(); n++; end
    if (!(ax == tx && ay == ty)) begin
      checks++; failures++;
      $display("FAIL run_to_a timeout got=(%0d,%0d) expected=(%0d,%0d)", ax, ay, tx, ty);
    end
  endtask

  task automatic run_to_b(int tx, int ty, int tfc);
    int n = 0;
    while (!(bx == tx && by == ty && (tfc < 0 || bfc == tfc)) && n < 40000) begin tick(); n++; end
    if (!(bx == tx && by == ty)) begin
      checks++; failures++;
      $display("FAIL run_to_b timeout got=(%0d,%0d) expected=(%0d,%0d)", bx, by, tx, ty);
    end
  endtask

  initial begin
    int n_de, n_hs, n_ls, n_vs, n_fs, n_bad;
    vecs[0]  = '{x:0,   y:0,  de:1'b1, col:7'd0,  row:5'd0, gx:3'd0, gy:4'd0, hs:1'b1, ls:1'b1};
    vecs[1]  = '{x:7,   y:0,  de:1'b1, col:7'd0,  row:5'd0, gx:3'd7, gy:4'd0, hs:1'b1, ls:1'b0};
    vecs[2]  = '{x:8,   y:0,  de:1'b1, col:7'd1,  row:5'd0, gx:3'd0, gy:4'd0, hs:1'b1, ls:1'b0};
    vecs[3]  = '{x:639, y:0,  de:1'b1, col:7'd79, row:5'd0, gx:3'd7, gy:4'd0, hs:1'b1, ls:1'b0};
    vecs[4]  = '{x:640, y:0,  de:1'b0, col:7'd0,  row:5'd0, gx:3'd0, gy:4'd0, hs:1'b1, ls:1'b0};
    vecs[5]  = '{x:655, y:0,  de:1'b0, col:7'd0,  row:5'd0, gx:3'd0, gy:4'd0, hs:1'b1, ls:1'b0};
    vecs[6]  = '{x:656, y:0,  de:1'b0, col:7'd0,  row:5'd0, gx:3'd0, gy:4'd0, hs:1'b0, ls:1'b0};
    vecs[7]  = '{x:751, y:0,  de:1'b0, col:7'd0,  row:5'd0, gx:3'd0, gy:4'd0, hs:1'b0, ls:1'b0};
    vecs[8]  = '{x:752, y:0,  de:1'b0, col:7'd0,  row:5'd0, gx:3'd0, gy:4'd0, hs:1'b1, ls:1'b0};
    vecs[9]  = '{x:0,   y:1,  de:1'b1, col:7'd0,  row:5'd0, gx:3'd0, gy:4'd1, hs:1'b1, ls:1'b1};
    vecs[10] = '{x:8,   y:16, de:1'b1, col:7'd1,  row:5'd1, gx:3'd0, gy:4'd0, hs:1'b1, ls:1'b0};
    vecs[11] = '{x:640, y:16, de:1'b0, col:7'd0,  row:5'd1, gx:3'd0, gy:4'd0, hs:1'b1, ls:1'b0};
    vecs[12] = '{x:639, y:17, de:1'b1, col:7'd79, row:5'd1, gx:3'd7, gy:4'd1, hs:1'b1, ls:1'b0};

    ax = 0; ay = 0; afc = 0; bx = 0; by = 0; bfc = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) begin
      tick();
      check_int("rst_x", int'(x_a), AHT - 1);
      check_int("rst_y", int'(y_a), AVT - 1);
      check_int("rst_de", int'(de_a), 0);
      check_int("rst_hsync", int'(hs_a), 1);
      check_int("rst_fs", int'(fs_a), 0);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    check_int("rel_x", int'(x_a), 0);
    check_int("rel_y", int'(y_a), 0);
    check_int("rel_de", int'(de_a), 1);
    check_int("rel_fs", int'(fs_a), 1);
    check_int("rel_ls", int'(ls_a), 1);

    for (int i = 0; i < 13; i++) begin
      run_to_a(vecs[i].x, vecs[i].y);
      check_int($sformatf("vec%0d_de", i),  int'(de_a),  int'(vecs[i].de));
      check_int($sformatf("vec%0d_col", i), int'(col_a), int'(vecs[i].col));
      check_int($sformatf("vec%0d_row", i), int'(row_a), int'(vecs[i].row));
      check_int($sformatf("vec%0d_gx", i),  int'(gx_a),  int'(vecs[i].gx));
      check_int($sformatf("vec%0d_gy", i),  int'(gy_a),  int'(vecs[i].gy));
      check_int($sformatf("vec%0d_hs", i),  int'(hs_a),  int'(vecs[i].hs));
      check_int($sformatf("vec%0d_ls", i),  int'(ls_a),  int'(vecs[i].ls));
    end

    // One full line: DE run, HSYNC width and LINE_START period.
    run_to_a(0, 18);
    n_de = 0; n_hs = 0; n_ls = 0;
    for (int i = 0; i < AHT; i++) begin
      n_de += int'(de_a); n_hs += int'(!hs_a); n_ls += int'(ls_a);
      tick();
    end
    check_int("line_de_clocks", n_de, 640);
    check_int("line_hsync_low", n_hs, 96);
    check_int("line_ls_count", n_ls, 1);
    check_int("line_period_ls", int'(ls_a), 1);

    // Mid-frame reset on the default instance.
    run_to_a(700, 19);
    rst_a = 1'b1;
    tick();
    check_int("midrst_x", int'(x_a), AHT - 1);
    check_int("midrst_y", int'(y_a), AVT - 1);
    check_int("midrst_de", int'(de_a), 0);
    rst_a = 1'b0;
    tick();
    check_int("midrst_next_x", int'(x_a), 0);
    check_int("midrst_next_fs", int'(fs_a), 1);

    // Small instance: fresh reset, frame-level counts, cell boundary, blink phases.
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    tick();
    check_int("b_rel_fs", int'(fs_b), 1);
    n_de = 0; n_vs = 0; n_fs = 0; n_bad = 0;
    for (int i = 0; i < BHT * BVT; i++) begin
      n_de += int'(de_b); n_vs += int'(!vs_b); n_fs += int'(fs_b);
      n_bad += int'(de_b && by >= BVA);
      tick();
    end
    check_int("frame_de_clocks", n_de, BHA * BVA);
    check_int("frame_vsync_low", n_vs, BVS * BHT);
    check_int("frame_fs_count", n_fs, 1);
    check_int("frame_de_in_vblank", n_bad, 0);
    check_int("frame_period_fs", int'(fs_b), 1);

    run_to_b(15, 15, -1);
    check_int("b_last_col", int'(col_b), 1);
    check_int("b_last_gx", int'(gx_b), 7);
    check_int("b_last_gy", int'(gy_b), 15);
    check_int("b_last_de", int'(de_b), 1);
    tick();
    check_int("b_after_de", int'(de_b), 0);
    check_int("b_after_col", int'(col_b), 0);

    run_to_b(0, 0, 31);
    check_int("blink_31", int'(bl_b), 0);
    run_to_b(0, 0, 32);
    check_int("blink_32", int'(bl_b), BLINK_ON ? 1 : 0);
    run_to_b(0, 0, 63);
    check_int("blink_63", int'(bl_b), BLINK_ON ? 1 : 0);
    run_to_b(0, 0, 64);
    check_int("blink_64", int'(bl_b), 0);

    finish_run();
  end

endmodule

// File: doc/vga_text_timing.md
# vga_text_timing

Raster timing generator for the qrzCore text display, clocked from the on-chip oscillator clock. Produces registered horizontal/vertical sync, display-enable and pixel position, plus 8x16 character-cell coordinates (column, row, glyph x/y) and frame/line strobes. It sits directly upstream of the text renderer, which uses these outputs to address the character buffer and font ROM. Default geometry is 640x480 at 800x525 totals.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, HSYNC active level (0 = active-low)
- VS_POL, 0, VSYNC active level
- CLK  in  1  pixel clock. One clock; reset is synchronous and active-high.
- RESET  in  1  synchronous, active-high
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- DE  out  1  display enable, high only in H and V active region
- X  out  10  horizontal counter, 0..H_TOTAL-1
- Y  out  10  vertical counter, 0..V_TOTAL-1
- COL  out  7  character column, X[9:3] when DE, else 0
- ROW  out  5  character row, Y[8:4] when V active, else 0
- GLYPH_X  out  3  X[2:0] when DE, else 0
- GLYPH_Y  out  4  Y[3:0] when V active, else 0
- LINE_START  out  1  one-cycle pulse at X=0
- FRAME_START  out  1  one-cycle pulse at X=0,Y=0
- BLINK  out  1  cursor/attribute blink phase

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must fit 10 bits; H_ACTIVE multiple of 8, V_ACTIVE multiple of 16.
- Horizontal FSM states: H_ACT (X < H_ACTIVE), H_FRONT, H_SYNCS, H_BACK; transitions on X reaching each boundary; H_BACK -> H_ACT at X wrap H_TOTAL-1 -> 0.
- Vertical FSM states V_ACT, V_FRONT, V_SYNCS, V_BACK; advance only on cycles where X wraps; Y wraps V_TOTAL-1 -> 0.
- X increments every clock; Y increments when X = H_TOTAL-1.
- HSYNC = HS_POL while X in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), else ~HS_POL. VSYNC likewise on Y (490..491), changing only at X=0.
- All outputs registered; all are mutually aligned (describe the same X,Y in the same cycle).
- Reset: X=H_TOTAL-1, Y=V_TOTAL-1, DE=0, HSYNC=~HS_POL, VSYNC=~VS_POL, COL=ROW=GLYPH_X=GLYPH_Y=0, LINE_START=0, FRAME_START=0, BLINK=0, blink counter 0. FSMs in H_BACK/V_BACK.
- RESET asserted mid-frame: next edge forces reset values regardless of state; counters never stall.

## Timing
- First cycle after RESET falls: X=0, Y=0, DE=1, LINE_START=1, FRAME_START=1, COL=0, ROW=0.
- DE high for exactly H_ACTIVE consecutive clocks per active line; 0 for whole of lines Y>=V_ACTIVE.
- Frame period exactly H_TOTAL*V_TOTAL clocks (420000); FRAME_START spacing identical.
- COL increments every 8 clocks inside active (X=8 -> COL=1, GLYPH_X=0); X=639 -> COL=79, GLYPH_X=7; X=640 -> COL=0, DE=0.
- ROW increments every 16 lines (Y=16 -> ROW=1); Y=479 -> ROW=29, GLYPH_Y=15.
- Zero-latency relation between X/Y and decoded outputs (decode from next-state values).

## Configuration
- VGA_TEXT_TIMING_BLINK_EN defined: 5-bit frame counter increments on each FRAME_START; BLINK toggles when counter wraps 31->0 (BLINK period 64 frames, each phase 32 frames). Counter and BLINK cleared by RESET.
- Undefined: counter not built, BLINK tied to 0.

## Test plan
- Hold RESET 3 clocks -> all outputs at reset values each cycle; release -> next cycle X=0,Y=0,DE=1,FRAME_START=1.
- Run one line -> DE high 640 clocks, HSYNC low clocks 656..751 (96 clocks), LINE_START once at X=0, 800-clock period.
- Run full frame -> VSYNC low for lines 490..491 (1600 clocks) starting at X=0, FRAME_START repeats after 420000 clocks, DE never high for Y>=480.
- Check cell decode: (X=8,Y=16) -> COL=1,ROW=1,GLYPH_X=0,GLYPH_Y=0; (639,479) -> 79,29,7,15; (640,100) -> COL=0,GLYPH_X=0,DE=0.
- Assert RESET at X=700,Y=300 for 1 clock -> next cycle reset values, following cycle (0,0) with FRAME_START.
- BLINK_EN defined: BLINK rises after 32nd FRAME_START, falls after 64th; undefined: BLINK stays 0 across 64 frames.
